// File: rtl/traffic_pkg.sv
// Shared encodings, default light durations and timer state type for the
// traffic-light controller and its interval timer.
package traffic_pkg;

  localparam logic [1:0] INT_BASE = 2'b00;
  localparam logic [1:0] INT_EXT  = 2'b01;
  localparam logic [1:0] INT_YEL  = 2'b10;

  localparam int DEF_T_BASE = 6;
  localparam int DEF_T_EXT  = 3;
  localparam int DEF_T_YEL  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_e;

endpackage

// File: rtl/traffic_interval_timer_if.sv
// Control, programming and status bundle between the traffic-light FSM
// (master) and the interval timer (slave).
interface traffic_interval_timer_if #(
  parameter int CNT_W = 4
);

  logic             start_t;
  logic [1:0]       interval;
  logic             prog_sync;
  logic [1:0]       time_param_sel;
  logic [CNT_W-1:0] time_value;
  logic             expired;
  logic             busy;
  logic [CNT_W-1:0] remaining;

  modport master (
    output start_t, interval, prog_sync, time_param_sel, time_value,
    input  expired, busy, remaining
  );

  modport slave (
    input  start_t, interval, prog_sync, time_param_sel, time_value,
    output expired, busy, remaining
  );

endinterface

// File: rtl/traffic_interval_timer_tick_divider.sv
// Free-running 0..TICK_DIV-1 divider producing a one-cycle tick on its last
// count; clear restarts it so the next tick is a full period away.
module tick_divider #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset_sync_n,
  input  logic clear,
  output logic tick
);

  localparam int CNT_DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_DW-1:0] LAST_C = CNT_DW'(TICK_DIV - 1);
  localparam logic [CNT_DW-1:0] ONE_C  = CNT_DW'(1);

  logic [CNT_DW-1:0] cnt_r;

  assign tick = (cnt_r == LAST_C);

  // Divider counter: clear has priority over wrap.
  always_ff @(posedge clk) begin
    if (!reset_sync_n) begin
      cnt_r <= {CNT_DW{1'b0}};
    end else if (clear || tick) begin
      cnt_r <= {CNT_DW{1'b0}};
    end else begin
      cnt_r <= cnt_r + ONE_C;
    end
  end

endmodule

// File: rtl/traffic_interval_timer.sv
// Programmable light-duration countdown in 1 s ticks with a one-cycle expiry
// pulse. Define TIMER_FAST_SIM_EN to shrink the tick period to 4 clocks.
module traffic_interval_timer
  import traffic_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int CNT_W      = 4,
  parameter int T_BASE_DEF = DEF_T_BASE,
  parameter int T_EXT_DEF  = DEF_T_EXT,
  parameter int T_YEL_DEF  = DEF_T_YEL
) (
  input  logic                    clk,
  input  logic                    reset_sync_n,
  traffic_interval_timer_if.slave bus
);

`ifdef TIMER_FAST_SIM_EN
  localparam int TICK_DIV = 4;
`else
  localparam int TICK_DIV = CLK_HZ;
`endif

  localparam logic [CNT_W-1:0] BASE_DEF_C = CNT_W'(T_BASE_DEF);
  localparam logic [CNT_W-1:0] EXT_DEF_C  = CNT_W'(T_EXT_DEF);
  localparam logic [CNT_W-1:0] YEL_DEF_C  = CNT_W'(T_YEL_DEF);
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

  // A zero write means "restore the default", so a zero duration never loads.
  function automatic logic [CNT_W-1:0] value_or_default(
    input logic [CNT_W-1:0] value,
    input logic [CNT_W-1:0] def
  );
    return (value == {CNT_W{1'b0}}) ? def : value;
  endfunction

  timer_state_e     state_r, state_n;
  logic [CNT_W-1:0] remaining_r, remaining_n;
  logic             busy_r, busy_n;
  logic             expired_r, expired_n;
  logic [CNT_W-1:0] t_base_r, t_ext_r, t_yel_r;
  logic [CNT_W-1:0] sel_dur_s;
  logic             tick_s;

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick_divider (
    .clk          (clk),
    .reset_sync_n (reset_sync_n),
    .clear        (bus.start_t),
    .tick         (tick_s)
  );

  // Duration select; the reserved code falls back to base green.
  always_comb begin
    case (bus.interval)
      INT_EXT: sel_dur_s = t_ext_r;
      INT_YEL: sel_dur_s = t_yel_r;
      default: sel_dur_s = t_base_r;
    endcase
  end

  // Duration programming registers.
  always_ff @(posedge clk) begin
    if (!reset_sync_n) begin
      t_base_r <= BASE_DEF_C;
      t_ext_r  <= EXT_DEF_C;
      t_yel_r  <= YEL_DEF_C;
    end else if (bus.prog_sync) begin
      case (bus.time_param_sel)
        INT_BASE: t_base_r <= value_or_default(bus.time_value, BASE_DEF_C);
        INT_EXT:  t_ext_r  <= value_or_default(bus.time_value, EXT_DEF_C);
        INT_YEL:  t_yel_r  <= value_or_default(bus.time_value, YEL_DEF_C);
        default:  t_base_r <= t_base_r;
      endcase
    end
  end

  // Next-state and next-output logic; a restart beats a coincident final tick.
  always_comb begin
    state_n     = state_r;
    remaining_n = remaining_r;
    expired_n   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start_t) begin
          remaining_n = sel_dur_s;
          state_n     = RUN;
        end else begin
          remaining_n = remaining_r;
        end
      end
      RUN: begin
        if (bus.start_t) begin
          remaining_n = sel_dur_s;
        end else if (tick_s && (remaining_r > ONE_C)) begin
          remaining_n = remaining_r - ONE_C;
        end else if (tick_s) begin
          remaining_n = {CNT_W{1'b0}};
          expired_n   = 1'b1;
          state_n     = IDLE;
        end else begin
          remaining_n = remaining_r;
        end
      end
      default: begin
        state_n     = IDLE;
        remaining_n = {CNT_W{1'b0}};
      end
    endcase
    busy_n = (state_n == RUN);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_sync_n) begin
      state_r     <= IDLE;
      remaining_r <= {CNT_W{1'b0}};
      busy_r      <= 1'b0;
      expired_r   <= 1'b0;
    end else begin
      state_r     <= state_n;
      remaining_r <= remaining_n;
      busy_r      <= busy_n;
      expired_r   <= expired_n;
    end
  end

  assign bus.expired   = expired_r;
  assign bus.busy      = busy_r;
  assign bus.remaining = remaining_r;

endmodule

// File: tb/tb_traffic_interval_timer.sv
// Directed checks of the interval timer with a 4-clock tick (CLK_HZ = 4).
module tb_traffic_interval_timer;
  import traffic_pkg::*;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset_sync_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  traffic_interval_timer_if #(.CNT_W(CNT_W)) tif ();

  traffic_interval_timer #(.CLK_HZ(4), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset_sync_n (reset_sync_n),
    .bus          (tif)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [1:0] sel, input logic [CNT_W-1:0] val);
    tif.prog_sync      = 1'b1;
    tif.time_param_sel = sel;
    tif.time_value     = val;
    step();
    tif.prog_sync      = 1'b0;
  endtask

  task automatic start_run(input logic [1:0] iv);
    tif.interval = iv;
    tif.start_t  = 1'b1;
    step();
    tif.start_t  = 1'b0;
  endtask

  // Steps until expired is seen; cyc counts edges since the start edge.
  task automatic wait_exp(input int base, input int budget, output int cyc);
    cyc = -1;
    for (int i = base + 1; i <= budget; i++) begin
      step();
      if (tif.expired === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic after_expiry(input string tag);
    step();
    check_eq({tag, "_single_pulse"}, tif.expired, 0);
    check_eq({tag, "_busy_done"}, tif.busy, 0);
    check_eq({tag, "_rem_done"}, tif.remaining, 0);
  endtask

  task automatic run_check(input logic [1:0] iv, input int exp_cyc, input string tag);
    int cyc;
    start_run(iv);
    check_eq({tag, "_no_exp_at_start"}, tif.expired, 0);
    check_eq({tag, "_busy"}, tif.busy, 1);
    wait_exp(0, exp_cyc + 8, cyc);
    check_eq({tag, "_latency"}, cyc, exp_cyc);
    after_expiry(tag);
  endtask

  initial begin
    int cyc;
    int saw;
    tif.start_t        = 1'b0;
    tif.interval       = 2'b00;
    tif.prog_sync      = 1'b0;
    tif.time_param_sel = 2'b00;
    tif.time_value     = 4'd0;

    step();
    step();
    check_eq("rst_expired", tif.expired, 0);
    check_eq("rst_busy", tif.busy, 0);
    check_eq("rst_remaining", tif.remaining, 0);
    reset_sync_n = 1'b1;
    step();

    // Base run: remaining walks 6..1, expiry on edge 24.
    start_run(2'b00);
    check_eq("base_busy", tif.busy, 1);
    saw = 0;
    for (int i = 1; i < 24; i++) begin
      step();
      if (tif.expired === 1'b1) saw++;
      if (i % 4 == 1) check_eq($sformatf("base_rem_c%0d", i), tif.remaining, 6 - i / 4);
    end
    check_eq("base_early_exp", saw, 0);
    step();
    check_eq("base_exp_c24", tif.expired, 1);
    check_eq("base_busy_c24", tif.busy, 0);
    after_expiry("base");

    run_check(2'b10, 8, "yel");
    run_check(2'b01, 12, "ext");
    run_check(2'b11, 24, "rsv");

    // Programming: write 5 then restore default via zero.
    prog(2'b01, 4'd5);
    run_check(2'b01, 20, "ext_prog5");
    prog(2'b01, 4'd0);
    run_check(2'b01, 12, "ext_prog0");
    prog(2'b11, 4'd9);
    run_check(2'b00, 24, "sel11_nowrite");

    // Same-cycle program and start on the yellow slot loads the old value.
    tif.prog_sync      = 1'b1;
    tif.time_param_sel = 2'b10;
    tif.time_value     = 4'd5;
    run_check(2'b10, 8, "prog_start_same");
    tif.prog_sync      = 1'b0;
    run_check(2'b10, 20, "yel_new");
    prog(2'b10, 4'd0);

    // Restart on clock 10 of a base run.
    start_run(2'b00);
    saw = 0;
    for (int i = 1; i < 10; i++) begin
      step();
      if (tif.expired === 1'b1) saw++;
    end
    check_eq("restart_no_exp", saw, 0);
    run_check(2'b00, 24, "restart");

    // Restart on the final-tick cycle of a yellow run.
    start_run(2'b10);
    saw = 0;
    for (int i = 1; i < 8; i++) begin
      step();
      if (tif.expired === 1'b1) saw++;
    end
    check_eq("final_tick_no_exp", saw, 0);
    check_eq("final_tick_rem1", tif.remaining, 1);
    run_check(2'b10, 8, "final_tick");

    // Mid-run reset aborts and restores defaults.
    prog(2'b00, 4'd9);
    prog(2'b01, 4'd7);
    prog(2'b10, 4'd4);
    start_run(2'b00);
    for (int i = 1; i <= 10; i++) step();
    reset_sync_n = 1'b0;
    step();
    reset_sync_n = 1'b1;
    check_eq("mrst_busy", tif.busy, 0);
    check_eq("mrst_remaining", tif.remaining, 0);
    saw = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (tif.expired === 1'b1) saw++;
    end
    check_eq("mrst_no_exp", saw, 0);
    run_check(2'b00, 24, "mrst_base");
    run_check(2'b10, 8, "mrst_yel");
    run_check(2'b01, 12, "mrst_ext");

    // Programming the active slot leaves the running countdown alone.
    start_run(2'b00);
    for (int i = 1; i <= 4; i++) step();
    prog(2'b00, 4'd2);
    wait_exp(5, 40, cyc);
    check_eq("prog_run_latency", cyc, 24);
    after_expiry("prog_run");
    run_check(2'b00, 8, "prog_run_next");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
